// File: rtl/parking_alloc.sv
// Parking-slot allocator: ALLOC / RELEASE / LOOKUP over NSLOTS plate registers
// using a fixed-length NSLOTS-cycle scan, with saturating per-slot occupancy timers.
module parking_alloc #(
    parameter int NSLOTS  = 6,
    parameter int NZONES  = 3,
    parameter int PLATE_W = 24,
    parameter int CNT_W   = 21,
    localparam int SW = $clog2(NSLOTS),
    localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1,
    localparam int OW = $clog2(NSLOTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ZW-1:0]      cmd_zone,
    input  logic [PLATE_W-1:0] cmd_plate,
    output logic               rsp_valid,
    output logic [2:0]         rsp_status,
    output logic [SW-1:0]      rsp_slot,
    output logic [CNT_W-1:0]   rsp_time,
    output logic [OW-1:0]      occ_count,
    output logic               full
);

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_ALLOC   = 2'b01;
    localparam logic [1:0] OP_RELEASE = 2'b10;
    localparam logic [1:0] OP_LOOKUP  = 2'b11;

    localparam logic [2:0] S_OK       = 3'd0;
    localparam logic [2:0] S_FULL     = 3'd1;
    localparam logic [2:0] S_NOTFOUND = 3'd2;
    localparam logic [2:0] S_DUP      = 3'd3;
    localparam logic [2:0] S_BADARG   = 3'd4;

    localparam logic [CNT_W-1:0] TMAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PLATE_W-1:0] r_plates [NSLOTS];
    logic [CNT_W-1:0]   r_timers [NSLOTS];

    logic [1:0]         r_op;
    logic [PLATE_W-1:0] r_plate;
    logic               r_bad;
    logic [SW-1:0]      r_idx;
    logic [SW-1:0]      r_k;
    logic               r_free_found;
    logic [SW-1:0]      r_free_slot;
    logic               r_match_found;
    logic [SW-1:0]      r_match_slot;
    logic [CNT_W-1:0]   r_match_time;

    logic               r_rsp_valid;
    logic [2:0]         r_rsp_status;
    logic [SW-1:0]      r_rsp_slot;
    logic [CNT_W-1:0]   r_rsp_time;
    logic [OW-1:0]      r_occ;
    logic               r_full;

    logic               w_accept;
    logic               w_zone_bad;
    logic [SW-1:0]      w_base;
    logic [SW-1:0]      w_idx_nxt;
    logic [2:0]         w_status;
    logic [SW-1:0]      w_slot;
    logic [CNT_W-1:0]   w_time;
    logic               w_commit_alloc;
    logic               w_commit_rel;
    logic [OW-1:0]      w_occ;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign w_accept   = cmd_valid && (r_state == ST_IDLE) && (cmd_op != OP_NOP);
    assign w_zone_bad = (32'(cmd_zone) >= 32'(NZONES));
    assign w_idx_nxt  = (r_idx == SW'(NSLOTS - 1)) ? {SW{1'b0}} : r_idx + SW'(1);

    assign rsp_valid  = r_rsp_valid;
    assign rsp_status = r_rsp_status;
    assign rsp_slot   = r_rsp_slot;
    assign rsp_time   = r_rsp_time;
    assign occ_count  = r_occ;
    assign full       = r_full;

    // Scan start: ALLOC starts in its zone, other ops always scan from slot 0.
    always_comb begin
        w_base = {SW{1'b0}};
        if ((cmd_op == OP_ALLOC) && !w_zone_bad) begin
            w_base = SW'((32'(cmd_zone) * 32'(NSLOTS)) / 32'(NZONES));
        end else begin
            w_base = {SW{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (r_k == SW'(NSLOTS - 1)) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch and per-cycle scan bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op          <= OP_NOP;
            r_plate       <= {PLATE_W{1'b0}};
            r_bad         <= 1'b0;
            r_idx         <= {SW{1'b0}};
            r_k           <= {SW{1'b0}};
            r_free_found  <= 1'b0;
            r_free_slot   <= {SW{1'b0}};
            r_match_found <= 1'b0;
            r_match_slot  <= {SW{1'b0}};
            r_match_time  <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op          <= cmd_op;
                        r_plate       <= cmd_plate;
                        r_bad         <= (cmd_plate == {PLATE_W{1'b0}}) ||
                                         ((cmd_op == OP_ALLOC) && w_zone_bad);
                        r_idx         <= w_base;
                        r_k           <= {SW{1'b0}};
                        r_free_found  <= 1'b0;
                        r_match_found <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if ((r_plates[r_idx] == {PLATE_W{1'b0}}) && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_slot  <= r_idx;
                    end
                    // Plate 0 would alias empty slots; it is rejected anyway.
                    if ((r_plates[r_idx] == r_plate) && (r_plate != {PLATE_W{1'b0}}) &&
                        !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_slot  <= r_idx;
                        r_match_time  <= r_timers[r_idx];
                    end
                    r_idx <= w_idx_nxt;
                    r_k   <= r_k + SW'(1);
                end
                default: begin
                    r_k <= {SW{1'b0}};
                end
            endcase
        end
    end

    // Outcome decode from the completed scan.
    always_comb begin
        w_status = S_OK;
        w_slot   = {SW{1'b0}};
        w_time   = {CNT_W{1'b0}};
        case (r_op)
            OP_ALLOC: begin
                if (r_bad) begin
                    w_status = S_BADARG;
                end else if (r_match_found) begin
                    w_status = S_DUP;
                    w_slot   = r_match_slot;
                end else if (!r_free_found) begin
                    w_status = S_FULL;
                end else begin
                    w_status = S_OK;
                    w_slot   = r_free_slot;
                end
            end
            OP_RELEASE: begin
                if (r_bad) begin
                    w_status = S_BADARG;
                end else if (r_match_found) begin
                    w_status = S_OK;
                    w_slot   = r_match_slot;
                    w_time   = r_timers[r_match_slot];
                end else begin
                    w_status = S_NOTFOUND;
                end
            end
            OP_LOOKUP: begin
                if (r_bad) begin
                    w_status = S_BADARG;
                end else if (r_match_found) begin
                    w_status = S_OK;
                    w_slot   = r_match_slot;
                    w_time   = r_match_time;
                end else begin
                    w_status = S_NOTFOUND;
                end
            end
            default: w_status = S_BADARG;
        endcase
    end

    // Only successful ALLOC / RELEASE modify slot state, on the RESP edge.
    always_comb begin
        w_commit_alloc = 1'b0;
        w_commit_rel   = 1'b0;
        if ((r_state == ST_RESP) && (w_status == S_OK)) begin
            w_commit_alloc = (r_op == OP_ALLOC);
            w_commit_rel   = (r_op == OP_RELEASE);
        end else begin
            w_commit_alloc = 1'b0;
            w_commit_rel   = 1'b0;
        end
    end

    // Slot plates and saturating occupancy timers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSLOTS; i++) begin
            if (rst) begin
                r_plates[i] <= {PLATE_W{1'b0}};
                r_timers[i] <= {CNT_W{1'b0}};
            end else if (w_commit_alloc && (r_free_slot == SW'(i))) begin
                r_plates[i] <= r_plate;
                r_timers[i] <= {CNT_W{1'b0}};
            end else if (w_commit_rel && (r_match_slot == SW'(i))) begin
                r_plates[i] <= {PLATE_W{1'b0}};
                r_timers[i] <= {CNT_W{1'b0}};
            end else if ((r_plates[i] != {PLATE_W{1'b0}}) && (r_timers[i] != TMAX)) begin
                r_timers[i] <= r_timers[i] + CNT_W'(1);
            end else begin
                r_timers[i] <= r_timers[i];
            end
        end
    end

    // Occupied-slot population count.
    always_comb begin
        w_occ = {OW{1'b0}};
        for (int i = 0; i < NSLOTS; i++) begin
            w_occ = w_occ + OW'(r_plates[i] != {PLATE_W{1'b0}});
        end
    end

    // Registered response strobe/fields and occupancy status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= 3'd0;
            r_rsp_slot   <= {SW{1'b0}};
            r_rsp_time   <= {CNT_W{1'b0}};
            r_occ        <= {OW{1'b0}};
            r_full       <= 1'b0;
        end else begin
            r_rsp_valid <= (r_state == ST_RESP);
            if (r_state == ST_RESP) begin
                r_rsp_status <= w_status;
                r_rsp_slot   <= w_slot;
                r_rsp_time   <= w_time;
            end
            r_occ  <= w_occ;
            r_full <= (w_occ == OW'(NSLOTS));
        end
    end

endmodule

// File: tb/tb_parking_alloc.sv
// Bench for parking_alloc: directed scenarios plus random commands checked against
// an array-based slot model; a CNT_W=4 twin sees the same stimulus to exercise saturation.
module tb_parking_alloc;

    localparam int NS  = 6;
    localparam int NZ  = 3;
    localparam int PW  = 24;
    localparam int CW  = 21;
    localparam int CWS = 4;

    localparam logic [1:0] OP_ALLOC   = 2'b01;
    localparam logic [1:0] OP_RELEASE = 2'b10;
    localparam logic [1:0] OP_LOOKUP  = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [1:0]    cmd_zone;
    logic [PW-1:0] cmd_plate;

    logic          cmd_ready,  s_cmd_ready;
    logic          rsp_valid,  s_rsp_valid;
    logic [2:0]    rsp_status, s_rsp_status;
    logic [2:0]    rsp_slot,   s_rsp_slot;
    logic [CW-1:0] rsp_time;
    logic [CWS-1:0] s_rsp_time;
    logic [2:0]    occ_count,  s_occ_count;
    logic          full,       s_full;

    parking_alloc #(.NSLOTS(NS), .NZONES(NZ), .PLATE_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_zone(cmd_zone), .cmd_plate(cmd_plate),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_slot(rsp_slot),
        .rsp_time(rsp_time), .occ_count(occ_count), .full(full)
    );

    parking_alloc #(.NSLOTS(NS), .NZONES(NZ), .PLATE_W(PW), .CNT_W(CWS)) u_sat (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(cmd_op), .cmd_zone(cmd_zone), .cmd_plate(cmd_plate),
        .rsp_valid(s_rsp_valid), .rsp_status(s_rsp_status), .rsp_slot(s_rsp_slot),
        .rsp_time(s_rsp_time), .occ_count(s_occ_count), .full(s_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    logic [PW-1:0] m_plate  [NS];
    longint        m_commit [NS];
    logic [PW-1:0] pool     [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_occ();
        int n = 0;
        for (int i = 0; i < NS; i++) if (m_plate[i] != '0) n++;
        return n;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One command: present, track the response against the model, then check occupancy.
    task automatic do_cmd(input logic [1:0] op, input int zone, input logic [PW-1:0] plate,
                          input bit junk);
        int     base, free_s, match_s, s, waited, e_status, e_slot;
        bit     bad;
        longint acc, e_time;
        @(negedge clk);
        chk("ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_zone  = 2'(zone);
        cmd_plate = plate;
        @(negedge clk);
        acc       = cyc;
        cmd_valid = 1'b0;

        bad  = (plate == '0) || ((op == OP_ALLOC) && (zone >= NZ));
        base = ((op == OP_ALLOC) && (zone < NZ)) ? (zone * NS) / NZ : 0;
        free_s  = -1;
        match_s = -1;
        for (int k = 0; k < NS; k++) begin
            s = (base + k) % NS;
            if ((m_plate[s] == '0) && (free_s < 0)) free_s = s;
            if ((plate != '0) && (m_plate[s] == plate) && (match_s < 0)) match_s = s;
        end
        e_slot = 0;
        e_time = 0;
        if (bad) e_status = 4;
        else if (op == OP_ALLOC) begin
            if (match_s >= 0)      begin e_status = 3; e_slot = match_s; end
            else if (free_s < 0)   e_status = 1;
            else                   begin e_status = 0; e_slot = free_s; end
        end else if (match_s < 0) e_status = 2;
        else begin
            e_status = 0;
            e_slot   = match_s;
            // LOOKUP samples during scan cycle k == slot; RELEASE reads just before the RESP edge.
            if (op == OP_LOOKUP) e_time = acc + match_s - m_commit[match_s];
            else                 e_time = acc + NS - m_commit[match_s];
        end

        waited = 0;
        while (!rsp_valid && (waited < 20)) begin
            if (junk) begin
                cmd_valid = 1'($urandom % 2);
                cmd_op    = OP_ALLOC;
                cmd_zone  = 2'($urandom % 3);
                cmd_plate = 24'($urandom);
            end
            @(negedge clk);
            waited++;
        end
        cmd_valid = 1'b0;
        chk("latency", 64'(cyc - acc), 64'(NS + 1));
        chk("status", 64'(rsp_status), 64'(e_status));
        chk("sat_status", 64'(s_rsp_status), 64'(e_status));
        if ((e_status == 0) || (e_status == 3)) begin
            chk("slot", 64'(rsp_slot), 64'(e_slot));
            chk("sat_slot", 64'(s_rsp_slot), 64'(e_slot));
        end
        chk("time", 64'(rsp_time), 64'(sat(e_time, CW)));
        chk("sat_time", 64'(s_rsp_time), 64'(sat(e_time, CWS)));

        if ((e_status == 0) && (op == OP_ALLOC)) begin
            m_plate[e_slot]  = plate;
            m_commit[e_slot] = acc + NS + 1;
        end else if ((e_status == 0) && (op == OP_RELEASE)) begin
            m_plate[e_slot] = '0;
        end

        @(negedge clk);
        chk("pulse_once", 64'(rsp_valid), 64'd0);
        chk("occ", 64'(occ_count), 64'(model_occ()));
        chk("full", 64'(full), 64'(model_occ() == NS));
        chk("sat_occ", 64'(s_occ_count), 64'(model_occ()));
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < NS; i++) begin m_plate[i] = '0; m_commit[i] = 0; end
        for (int i = 0; i < 8; i++) pool[i] = 24'h300000 + 24'(i * 24'h111);
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_zone = 2'd0; cmd_plate = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_status", 64'(rsp_status), 64'd0);
        chk("rst_slot", 64'(rsp_slot), 64'd0);
        chk("rst_time", 64'(rsp_time), 64'd0);
        chk("rst_occ", 64'(occ_count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);

        // Zone 1 of 3 with 6 slots starts the scan at slot 2.
        do_cmd(OP_ALLOC, 1, 24'hABC123, 1'b0);
        chk("first_slot", 64'(rsp_slot), 64'd2);
        do_cmd(OP_ALLOC, 0, 24'hABC123, 1'b0);
        do_cmd(OP_ALLOC, 0, 24'h000000, 1'b0);
        do_cmd(OP_ALLOC, 3, 24'h123456, 1'b0);
        for (int i = 0; i < 5; i++) do_cmd(OP_ALLOC, 0, 24'h100001 + 24'(i), 1'b1);
        chk("fill_full", 64'(full), 64'd1);
        do_cmd(OP_ALLOC, 1, 24'h777777, 1'b0);
        do_cmd(OP_RELEASE, 0, m_plate[0], 1'b0);
        do_cmd(OP_ALLOC, 2, 24'h222222, 1'b0);
        chk("zone2_wrap", 64'(rsp_slot), 64'd0);

        repeat (100) @(negedge clk);
        do_cmd(OP_LOOKUP, 0, 24'hABC123, 1'b0);
        chk("sat_15", 64'(s_rsp_time), 64'd15);
        do_cmd(OP_RELEASE, 0, 24'hABC123, 1'b0);
        do_cmd(OP_RELEASE, 0, 24'hABC123, 1'b0);

        // Clear the table so random traffic starts from a known state.
        for (int i = 0; i < NS; i++) if (m_plate[i] != '0) do_cmd(OP_RELEASE, 0, m_plate[i], 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [1:0]    op;
            logic [PW-1:0] pl;
            op = 2'($urandom_range(1, 3));
            pl = (($urandom % 10) == 0) ? 24'h000000 : pool[$urandom % 8];
            do_cmd(op, int'($urandom % 4), pl, 1'($urandom % 2));
            repeat ($urandom % 20) @(negedge clk);
        end

        // Reset in the middle of a scan.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ALLOC; cmd_zone = 2'd0; cmd_plate = 24'h5A5A5A;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NS; i++) m_plate[i] = '0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        chk("mid_rst_pulse", 64'(pulses), 64'd0);
        chk("mid_rst_occ", 64'(occ_count), 64'd0);
        chk("mid_rst_full", 64'(full), 64'd0);
        do_cmd(OP_LOOKUP, 0, 24'h5A5A5A, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/parking_alloc.md
PARKING_ALLOC -- requirements
Module: parking_alloc

Interface
REQ-001 SHALL have parameter NSLOTS, default 6: number of parking slots (>=2).
REQ-002 SHALL have parameter NZONES, default 3: number of zones (1..NSLOTS).
REQ-003 SHALL have parameter PLATE_W, default 24: plate width; plate value 0 means empty slot.
REQ-004 SHALL have parameter CNT_W, default 21: per-slot occupancy timer width.
REQ-005 SHALL have derived widths SW = clog2(NSLOTS), ZW = max(1, clog2(NZONES)), OW = clog2(NSLOTS+1).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cmd_valid  in  1  command present.
REQ-009 cmd_ready  out  1  block idle and able to accept a command.
REQ-010 cmd_op  in  2  00 NOP, 01 ALLOC, 10 RELEASE, 11 LOOKUP.
REQ-011 cmd_zone  in  ZW  preferred zone, used by ALLOC only.
REQ-012 cmd_plate  in  PLATE_W  plate operand.
REQ-013 rsp_valid  out  1  one-cycle response strobe.
REQ-014 rsp_status  out  3  0 OK, 1 FULL, 2 NOTFOUND, 3 DUP, 4 BADARG.
REQ-015 rsp_slot  out  SW  0-based slot index of the result.
REQ-016 rsp_time  out  CNT_W  timer of the matched slot (RELEASE, LOOKUP); 0 otherwise.
REQ-017 occ_count  out  OW  number of occupied slots.
REQ-018 full  out  1  high when occ_count == NSLOTS.

Function
REQ-019 SHALL implement FSM IDLE -> SCAN -> RESP -> IDLE; cmd_ready = (state==IDLE).
REQ-020 SHALL accept a command on the edge where cmd_valid & cmd_ready & cmd_op!=NOP; operands latched there; NOP never accepted.
REQ-021 SCAN SHALL last exactly NSLOTS cycles, examining slot (base+k) mod NSLOTS at scan cycle k=0..NSLOTS-1.
REQ-022 base SHALL be (cmd_zone*NSLOTS)/NZONES for ALLOC; 0 for RELEASE and LOOKUP.
REQ-023 rsp_valid SHALL be high for exactly one cycle (RESP), NSLOTS+1 cycles after the acceptance edge, for every op; latency is independent of outcome.
REQ-024 rsp_status, rsp_slot, rsp_time SHALL be valid only while rsp_valid is high; otherwise they hold their last values.
REQ-025 ALLOC SHALL record the first empty slot in scan order and any slot whose plate equals the operand.
REQ-026 ALLOC outcome priority: BADARG (plate 0 or zone>=NZONES) > DUP (match found; rsp_slot = matching slot) > FULL (no empty slot) > OK (first empty slot written).
REQ-027 ALLOC-OK SHALL write the plate and clear the slot timer on the RESP edge.
REQ-028 RELEASE SHALL return OK with slot index and pre-clear timer value, then clear plate and timer on the RESP edge; no match gives NOTFOUND; plate 0 gives BADARG.
REQ-029 LOOKUP SHALL return OK with slot and timer value sampled at the match scan cycle, with no state change; otherwise NOTFOUND or BADARG as for RELEASE.
REQ-030 BADARG, DUP, FULL and NOTFOUND SHALL leave all slot state unchanged.
REQ-031 Each occupied slot timer SHALL increment by 1 every cycle and saturate at 2^CNT_W-1, never wrapping; empty slot timers SHALL hold 0.
REQ-032 occ_count and full SHALL be registered, reflecting a commit one cycle after the RESP edge.
REQ-033 Commands presented while cmd_ready is low SHALL be ignored, not queued.

Reset
REQ-034 On rst high at a clock edge: state IDLE, all plates 0, all timers 0, rsp_valid 0, rsp_status 0, rsp_slot 0, rsp_time 0, occ_count 0, full 0.
REQ-035 rst during SCAN or RESP SHALL abort the command with no rsp_valid pulse and no commit; rst overrides every other input.

Verification
REQ-036 After reset, ALLOC zone 1 plate 0xABC123 -> rsp_valid exactly 7 cycles after acceptance, status OK, slot 2; occ_count 1 one cycle later.
REQ-037 Repeat ALLOC 0xABC123 zone 0 -> status DUP, slot 2, occ_count stays 1; ALLOC plate 0 -> BADARG; ALLOC zone 3 -> BADARG.
REQ-038 Fill all 6 slots -> full=1, occ_count 6; a 7th distinct ALLOC -> FULL with no state change; ALLOC zone 2 while slots 4,5 are occupied and 0 is free -> slot 0.
REQ-039 LOOKUP a plate 100 cycles after its commit -> OK, correct slot, rsp_time within 100+/-NSLOTS; RELEASE it -> OK, then occ_count decrements and full=0; RELEASE again -> NOTFOUND.
REQ-040 With CNT_W=4, one slot occupied for 40 cycles -> LOOKUP returns rsp_time 15 (saturated).
REQ-041 Assert rst in the middle of a SCAN -> no rsp_valid pulse, occ_count 0, cmd_ready high on the cycle after reset deasserts.
